lfsr_seq_ctrl: RTL and testbench

Sequencing controller for the team's LFSR pseudo-random bit source. It loads a seed through a valid/ready handshake, then runs a programmable number of Fibonacci LFSR steps. Each output bit is delivered on a valid/ready stream, so the shift register advances only when a consumer accepts a bit. Zero-seed lockup is detected and repaired, and completion is signalled to the system-level sequencer.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_core.sv | 74 +++++++
 rtl/lfsr_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequencing controller.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - default Fibonacci feedback tap mask
//   - parity helper used to form the feedback bit
package lfsr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // x^8 + x^4 + x^3 + x^2 + 1 (maximal-length for an 8-bit register)
  localparam logic [7:0] DEFAULT_TAPS = 8'h1D;

  // Widest register the parity helper handles; narrower values are zero-extended.
  localparam int PARITY_W = 32;

  function automatic logic parity(input logic [PARITY_W-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: N-bit Fibonacci LFSR register with seed load and zero-seed repair.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (state resets to 1)
//   load            : load load_value on the next edge (has priority over shift)
//   load_value [N]  : seed; a zero seed is replaced by 1 and flagged on lockup
//   shift_en        : advance one step: state <= {fb, state[N-1:1]}
//   state_q [N]     : current register contents
//   lockup          : one-cycle pulse, registered on the edge that repaired a zero seed
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] TAPS = N'(DEFAULT_TAPS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         shift_en,
  output logic [N-1:0] state_q,
  output logic         lockup
);

  localparam logic [N-1:0] STATE_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]          state_r;
  logic                  lockup_r;
  logic [PARITY_W-1:0]   masked_s;
  logic                  fb_s;
  logic [N-1:0]          next_s;
  logic                  repair_s;

  // Feedback bit: parity of the tapped state bits, zero-extended for the helper.
  always_comb begin
    masked_s          = '0;
    masked_s[N-1:0]   = state_r & TAPS;
    fb_s              = parity(masked_s);
  end

  // Next-state selection: load (with zero-seed repair), shift, or hold.
  always_comb begin
    next_s   = state_r;
    repair_s = 1'b0;
    if (load) begin
      if (load_value == '0) begin
        // An all-zero register would lock the LFSR forever.
        next_s   = STATE_ONE;
        repair_s = 1'b1;
      end else begin
        next_s   = load_value;
        repair_s = 1'b0;
      end
    end else if (shift_en) begin
      next_s = {fb_s, state_r[N-1:1]};
    end else begin
      next_s = state_r;
    end
  end

  // State register and registered lockup pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= STATE_ONE;
      lockup_r <= 1'b0;
    end else begin
      state_r  <= next_s;
      lockup_r <= repair_s;
    end
  end

  assign state_q = state_r;
  assign lockup  = lockup_r;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: sequences an LFSR bit source through seed load, a counted run
// of valid/ready bit transfers, and a completion pulse.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   seed_valid/seed_ready/seed_data : seed handshake, accepted only in IDLE
//   start, step_count          : begin a run of step_count bits (IDLE only)
//   abort                      : cancel a run (RUN only), no done pulse
//   bit_valid/bit_ready/bit_data    : output bit stream, bit_data = state_q[0]
//   state_q                    : LFSR contents
//   busy                       : high while running
//   done                       : one-cycle pulse after the last bit
//   lockup                     : one-cycle pulse when a zero seed was repaired
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int           N     = 8,
  parameter logic [N-1:0] TAPS  = N'(DEFAULT_TAPS),
  parameter int           CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [N-1:0]     seed_data,
  input  logic             start,
  input  logic [CNT_W-1:0] step_count,
  input  logic             abort,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_data,
  output logic [N-1:0]     state_q,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       fsm_r;
  logic [1:0]       fsm_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             load_s;
  logic             accept_s;

  // Handshake qualifiers; all controls decode from the state register so
  // bit_ready has no combinational path to bit_valid.
  assign seed_ready = (fsm_r == ST_IDLE);
  assign bit_valid  = (fsm_r == ST_RUN);
  assign busy       = (fsm_r == ST_RUN);
  assign done       = (fsm_r == ST_DONE);
  assign load_s     = seed_valid & seed_ready;
  assign accept_s   = bit_valid & bit_ready;
  assign bit_data   = state_q[0];

  lfsr_core #(
    .N    (N),
    .TAPS (TAPS)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_value (seed_data),
    .shift_en   (accept_s),
    .state_q    (state_q),
    .lockup     (lockup)
  );

  // FSM and step counter next-state logic.
  always_comb begin
    fsm_next_s = fsm_r;
    cnt_next_s = cnt_r;
    case (fsm_r)
      ST_IDLE: begin
        if (start) begin
          if (step_count != '0) begin
            cnt_next_s = step_count;
            fsm_next_s = ST_RUN;
          end else begin
            fsm_next_s = ST_DONE;
          end
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // A handshake in this cycle still shifts the core; only the run ends.
          cnt_next_s = '0;
          fsm_next_s = ST_IDLE;
        end else if (accept_s) begin
          cnt_next_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            fsm_next_s = ST_DONE;
          end else begin
            fsm_next_s = ST_RUN;
          end
        end else begin
          fsm_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        fsm_next_s = ST_IDLE;
      end
      default: begin
        // Unreachable encoding: recover to a quiet idle.
        cnt_next_s = '0;
        fsm_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_r <= ST_IDLE;
      cnt_r <= '0;
    end else begin
      fsm_r <= fsm_next_s;
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed self-checking bench for lfsr_seq_ctrl (N=8, TAPS=8'h1D, CNT_W=16).
module tb_lfsr_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        seed_valid;
  logic        seed_ready;
  logic [7:0]  seed_data;
  logic        start;
  logic [15:0] step_count;
  logic        abort;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_data;
  logic [7:0]  state_q;
  logic        busy;
  logic        done;
  logic        lockup;

  int checks   = 0;
  int failures = 0;

  lfsr_seq_ctrl #(.N(8), .TAPS(8'h1D), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .start      (start),
    .step_count (step_count),
    .abort      (abort),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bit_data   (bit_data),
    .state_q    (state_q),
    .busy       (busy),
    .done       (done),
    .lockup     (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [7:0] value);
    seed_valid = 1'b1;
    seed_data  = value;
    tick();
    seed_valid = 1'b0;
    seed_data  = 8'h00;
  endtask

  task automatic start_run(input logic [15:0] count);
    start      = 1'b1;
    step_count = count;
    tick();
    start      = 1'b0;
    step_count = 16'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (state_q !== 8'h01) begin failures++; $display("FAIL reset_state: got %h expected 01", state_q); end
    checks++; if ({seed_ready, busy, bit_valid, done, lockup} !== 5'b10000) begin failures++;
      $display("FAIL reset_outputs: got %b expected 10000", {seed_ready, busy, bit_valid, done, lockup}); end
  endtask

  task automatic test_basic_run();
    logic [4:0] exp_bits;
    exp_bits = 5'b00001; // bit i is the i-th emitted bit: 1,0,0,0,0
    load_seed(8'h01);
    checks++; if (state_q !== 8'h01 || lockup !== 1'b0) begin failures++;
      $display("FAIL basic_seed: got state %h lockup %b expected 01 0", state_q, lockup); end
    bit_ready = 1'b1;
    start_run(16'd5);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bit_valid !== 1'b1 || busy !== 1'b1 || bit_data !== exp_bits[i] || done !== 1'b0) begin failures++;
        $display("FAIL basic_bit%0d: got v%b b%b d%b done%b expected v1 b1 d%b done0", i, bit_valid, busy, bit_data, done, exp_bits[i]); end
      tick();
    end
    checks++; if (done !== 1'b1 || state_q !== 8'h88 || busy !== 1'b0 || bit_valid !== 1'b0) begin failures++;
      $display("FAIL basic_done: got done %b state %h busy %b expected 1 88 0", done, state_q, busy); end
    tick();
    checks++; if (done !== 1'b0 || seed_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL basic_after: got done %b seed_ready %b busy %b expected 0 1 0", done, seed_ready, busy); end
    bit_ready = 1'b0;
  endtask

  task automatic test_lockup_period();
    int first_return;
    load_seed(8'h00);
    checks++; if (lockup !== 1'b1 || state_q !== 8'h01) begin failures++;
      $display("FAIL lockup_pulse: got lockup %b state %h expected 1 01", lockup, state_q); end
    tick();
    checks++; if (lockup !== 1'b0) begin failures++; $display("FAIL lockup_width: got %b expected 0", lockup); end
    bit_ready = 1'b1;
    start_run(16'd255);
    first_return = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (state_q === 8'h01 && first_return == 0) first_return = k;
    end
    checks++; if (first_return != 255) begin failures++;
      $display("FAIL period: got first return at step %0d expected 255", first_return); end
    checks++; if (done !== 1'b1 || state_q !== 8'h01) begin failures++;
      $display("FAIL period_done: got done %b state %h expected 1 01", done, state_q); end
    bit_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_state [4];
    logic       pat [6];
    int         idx;
    exp_state = '{8'h01, 8'h80, 8'h40, 8'h20};
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    load_seed(8'h01);
    bit_ready = 1'b0;
    start_run(16'd3);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bit_ready = pat[c];
      checks++; if (bit_valid !== 1'b1 || state_q !== exp_state[idx] || bit_data !== exp_state[idx][0]) begin failures++;
        $display("FAIL bp_cycle%0d: got v%b state %h bit %b expected v1 %h %b", c, bit_valid, state_q, bit_data, exp_state[idx], exp_state[idx][0]); end
      tick();
      if (pat[c]) idx++;
    end
    bit_ready = 1'b0;
    checks++; if (done !== 1'b1 || state_q !== 8'h20 || bit_valid !== 1'b0) begin failures++;
      $display("FAIL bp_done: got done %b state %h valid %b expected 1 20 0", done, state_q, bit_valid); end
    tick();
  endtask

  task automatic test_zero_count();
    bit_ready = 1'b1;
    start_run(16'd0);
    checks++; if (done !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0 || state_q !== 8'h20) begin failures++;
      $display("FAIL zero_done: got done %b valid %b busy %b state %h expected 1 0 0 20", done, bit_valid, busy, state_q); end
    tick();
    checks++; if (done !== 1'b0 || bit_valid !== 1'b0 || seed_ready !== 1'b1 || state_q !== 8'h20) begin failures++;
      $display("FAIL zero_after: got done %b valid %b ready %b state %h expected 0 0 1 20", done, bit_valid, seed_ready, state_q); end
    bit_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] cont [3];
    cont = '{8'h40, 8'h20, 8'h10};
    load_seed(8'h01);
    bit_ready = 1'b1;
    start_run(16'd10);
    tick();
    tick();
    bit_ready = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    checks++; if (state_q !== 8'h40 || busy !== 1'b0 || done !== 1'b0 || seed_ready !== 1'b1) begin failures++;
      $display("FAIL abort_idle: got state %h busy %b done %b ready %b expected 40 0 0 1", state_q, busy, done, seed_ready); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_nodone: got %b expected 0", done); end
    bit_ready = 1'b1;
    start_run(16'd3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (state_q !== cont[i] || bit_valid !== 1'b1) begin failures++;
        $display("FAIL abort_cont%0d: got %h valid %b expected %h 1", i, state_q, bit_valid, cont[i]); end
      tick();
    end
    checks++; if (done !== 1'b1 || state_q !== 8'h88) begin failures++;
      $display("FAIL abort_cont_done: got done %b state %h expected 1 88", done, state_q); end
    bit_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    seed_valid = 1'b1;
    seed_data  = 8'h80;
    start      = 1'b1;
    step_count = 16'd2;
    bit_ready  = 1'b1;
    tick();
    seed_valid = 1'b0;
    start      = 1'b0;
    step_count = 16'd0;
    checks++; if (state_q !== 8'h80 || busy !== 1'b1) begin failures++;
      $display("FAIL b2b_start: got state %h busy %b expected 80 1", state_q, busy); end
    tick();
    tick();
    checks++; if (done !== 1'b1 || state_q !== 8'h20) begin failures++;
      $display("FAIL b2b_done: got done %b state %h expected 1 20", done, state_q); end
    bit_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    load_seed(8'h01);
    bit_ready = 1'b1;
    start_run(16'd10);
    tick();
    checks++; if (seed_ready !== 1'b0 || state_q !== 8'h80) begin failures++;
      $display("FAIL run_ready: got ready %b state %h expected 0 80", seed_ready, state_q); end
    seed_valid = 1'b1;
    seed_data  = 8'h55;
    start      = 1'b1;
    step_count = 16'd2;
    tick();
    seed_valid = 1'b0;
    start      = 1'b0;
    step_count = 16'd0;
    checks++; if (state_q !== 8'h40 || busy !== 1'b1 || lockup !== 1'b0) begin failures++;
      $display("FAIL run_ignore: got state %h busy %b lockup %b expected 40 1 0", state_q, busy, lockup); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state_q !== 8'h01 || {seed_ready, busy, bit_valid, done, lockup} !== 5'b10000) begin failures++;
      $display("FAIL midrun_reset: got state %h flags %b expected 01 10000", state_q, {seed_ready, busy, bit_valid, done, lockup}); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || state_q !== 8'h01) begin failures++;
      $display("FAIL after_reset: got done %b busy %b state %h expected 0 0 01", done, busy, state_q); end
    bit_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    seed_valid = 1'b0;
    seed_data  = 8'h00;
    start      = 1'b0;
    step_count = 16'd0;
    abort      = 1'b0;
    bit_ready  = 1'b0;
    test_reset();
    test_basic_run();
    test_lockup_period();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
